inst_mem_access: RTL and testbench

Memory-access stage downstream of the execute stage. It takes one retired execute result per handshake. ALU/CSR results pass through to writeback with one registered cycle. Loads and stores run a request/grant/response transaction on the data bus, with byte-lane steering, load sign/zero extension, misalignment detection and a bus timeout. Results are delivered to writeback as a single-cycle valid pulse.

---
 rtl/inst_mem_access_if.sv | 58 +++++
 rtl/inst_mem_access.sv | 268 ++++++++++++++++++++++++++
 tb/tb_inst_mem_access.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_access_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_access_if
// Brief    : Execute-side handshake, data-bus and writeback bundle for the
//            memory-access stage. "slave" is the stage's view, "master" is
//            the view of the surrounding pipeline/bus environment.
// Revision : 1.0 - initial release
// ============================================================================
interface inst_mem_access_if #(
  parameter int XLEN = 32
);
  // execute stage handshake
  logic            ex_valid_i;
  logic            ex_ready_o;
  logic [31:0]     ex_inst_i;
  logic [XLEN-1:0] ex_addr_i;
  logic [XLEN-1:0] ex_sdata_i;
  logic            ex_reg_wen_i;
  logic [4:0]      ex_reg_waddr_i;
  logic [XLEN-1:0] ex_reg_wdata_i;

  // data bus
  logic            mem_req_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [3:0]      mem_be_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;

  // writeback
  logic            wb_valid_o;
  logic            wb_reg_wen_o;
  logic [4:0]      wb_reg_waddr_o;
  logic [XLEN-1:0] wb_reg_wdata_o;
  logic [1:0]      wb_exc_o;

  modport slave (
    input  ex_valid_i, ex_inst_i, ex_addr_i, ex_sdata_i,
           ex_reg_wen_i, ex_reg_waddr_i, ex_reg_wdata_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output ex_ready_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
           wb_valid_o, wb_reg_wen_o, wb_reg_waddr_o, wb_reg_wdata_o, wb_exc_o
  );

  modport master (
    output ex_valid_i, ex_inst_i, ex_addr_i, ex_sdata_i,
           ex_reg_wen_i, ex_reg_waddr_i, ex_reg_wdata_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  ex_ready_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
           wb_valid_o, wb_reg_wen_o, wb_reg_waddr_o, wb_reg_wdata_o, wb_exc_o
  );
endinterface

`default_nettype wire

// File: rtl/inst_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_access
// Brief    : Memory-access pipeline stage. ALU/CSR results pass through to
//            writeback after one register; loads/stores run a req/gnt/rvalid
//            bus transaction with lane steering, load extension, alignment
//            checking and a bus timeout.
// Revision : 1.0 - initial release
// ============================================================================
module inst_mem_access #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  inst_mem_access_if.slave bus
);

  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [7:0] C_TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [1:0] C_EXC_NONE  = 2'b00;
  localparam logic [1:0] C_EXC_MISAL = 2'b01;
  localparam logic [1:0] C_EXC_BUS   = 2'b10;
  localparam logic [1:0] C_EXC_ILL   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_cnt, w_cnt_nxt;
  logic            r_is_load, w_is_load_nxt;
  logic [2:0]      r_funct3, w_funct3_nxt;
  logic [1:0]      r_off, w_off_nxt;
  logic [4:0]      r_waddr, w_waddr_nxt;

  logic            r_mem_req, w_mem_req_nxt;
  logic            r_mem_we, w_mem_we_nxt;
  logic [XLEN-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [XLEN-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [3:0]      r_mem_be, w_mem_be_nxt;

  logic            r_wb_valid, w_wb_valid_nxt;
  logic            r_wb_wen, w_wb_wen_nxt;
  logic [4:0]      r_wb_waddr, w_wb_waddr_nxt;
  logic [XLEN-1:0] r_wb_wdata, w_wb_wdata_nxt;
  logic [1:0]      r_wb_exc, w_wb_exc_nxt;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_is_load, w_is_store, w_is_mem;
  logic            w_legal, w_misaligned;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_st_data;
  logic            w_ready, w_accept;
  logic [XLEN-1:0] w_shifted, w_load_data;
  logic            w_unused;

  // Only opcode and funct3 of the instruction word matter here.
  assign w_unused = &{1'b0, bus.ex_inst_i[31:15], bus.ex_inst_i[11:7]};

  assign w_opcode   = bus.ex_inst_i[6:0];
  assign w_funct3   = bus.ex_inst_i[14:12];
  assign w_is_load  = (w_opcode == C_OP_LOAD);
  assign w_is_store = (w_opcode == C_OP_STORE);
  assign w_is_mem   = w_is_load || w_is_store;
  assign w_ready    = (r_state == S_IDLE) && !rst_i;
  assign w_accept   = bus.ex_valid_i && w_ready;

  // Decode legality, alignment and byte-lane steering of the incoming access.
  always_comb begin
    w_legal      = 1'b0;
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_st_data    = bus.ex_sdata_i;
    if (w_is_load) begin
      w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b010) ||
                (w_funct3 == 3'b100) || (w_funct3 == 3'b101);
    end else if (w_is_store) begin
      w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b010);
    end
    // funct3[1:0] is the access size for every legal encoding
    case (w_funct3[1:0])
      2'b00: begin
        w_be      = 4'b0001 << bus.ex_addr_i[1:0];
        w_st_data = {4{bus.ex_sdata_i[7:0]}};
      end
      2'b01: begin
        w_misaligned = bus.ex_addr_i[0];
        w_be         = bus.ex_addr_i[1] ? 4'b1100 : 4'b0011;
        w_st_data    = {2{bus.ex_sdata_i[15:0]}};
      end
      default: begin
        w_misaligned = |bus.ex_addr_i[1:0];
      end
    endcase
  end

  // Align the returned word to the addressed byte and extend to XLEN.
  always_comb begin
    w_shifted = bus.mem_rdata_i >> {r_off, 3'b000};
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
      3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  // Next-state and next-output logic of the stage controller.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_is_load_nxt   = r_is_load;
    w_funct3_nxt    = r_funct3;
    w_off_nxt       = r_off;
    w_waddr_nxt     = r_waddr;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_be_nxt    = r_mem_be;
    w_wb_valid_nxt  = 1'b0;
    w_wb_wen_nxt    = r_wb_wen;
    w_wb_waddr_nxt  = r_wb_waddr;
    w_wb_wdata_nxt  = r_wb_wdata;
    w_wb_exc_nxt    = r_wb_exc;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_wb_waddr_nxt = bus.ex_reg_waddr_i;
          if (!w_is_mem) begin
            w_wb_valid_nxt = 1'b1;
            w_wb_wen_nxt   = bus.ex_reg_wen_i && (bus.ex_reg_waddr_i != 5'd0);
            w_wb_wdata_nxt = bus.ex_reg_wdata_i;
            w_wb_exc_nxt   = C_EXC_NONE;
          end else if (!w_legal || w_misaligned) begin
            w_wb_valid_nxt = 1'b1;
            w_wb_wen_nxt   = 1'b0;
            w_wb_wdata_nxt = '0;
            w_wb_exc_nxt   = !w_legal ? C_EXC_ILL : C_EXC_MISAL;
          end else begin
            w_state_nxt     = S_REQ;
            w_cnt_nxt       = 8'd0;
            w_is_load_nxt   = w_is_load;
            w_funct3_nxt    = w_funct3;
            w_off_nxt       = bus.ex_addr_i[1:0];
            w_waddr_nxt     = bus.ex_reg_waddr_i;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = w_is_store;
            w_mem_addr_nxt  = {bus.ex_addr_i[XLEN-1:2], 2'b00};
            w_mem_wdata_nxt = w_is_store ? w_st_data : '0;
            w_mem_be_nxt    = w_be;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_gnt_i) begin
          w_mem_req_nxt = 1'b0;
          w_cnt_nxt     = 8'd0;
          if (r_is_load) begin
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt    = S_DONE;
            w_wb_valid_nxt = 1'b1;
            w_wb_wen_nxt   = 1'b0;
            w_wb_waddr_nxt = r_waddr;
            w_wb_exc_nxt   = C_EXC_NONE;
          end
        end else if (r_cnt == C_TO_LAST) begin
          // request is abandoned and reported as a bus error
          w_mem_req_nxt  = 1'b0;
          w_state_nxt    = S_DONE;
          w_wb_valid_nxt = 1'b1;
          w_wb_wen_nxt   = 1'b0;
          w_wb_waddr_nxt = r_waddr;
          w_wb_exc_nxt   = C_EXC_BUS;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid_i) begin
          w_state_nxt    = S_DONE;
          w_wb_valid_nxt = 1'b1;
          w_wb_wen_nxt   = (r_waddr != 5'd0);
          w_wb_waddr_nxt = r_waddr;
          w_wb_wdata_nxt = w_load_data;
          w_wb_exc_nxt   = C_EXC_NONE;
        end else if (r_cnt == C_TO_LAST) begin
          w_state_nxt    = S_DONE;
          w_wb_valid_nxt = 1'b1;
          w_wb_wen_nxt   = 1'b0;
          w_wb_waddr_nxt = r_waddr;
          w_wb_exc_nxt   = C_EXC_BUS;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, captured context and registered outputs; reset aborts any transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_is_load   <= 1'b0;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
      r_waddr     <= 5'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= 4'd0;
      r_wb_valid  <= 1'b0;
      r_wb_wen    <= 1'b0;
      r_wb_waddr  <= 5'd0;
      r_wb_wdata  <= '0;
      r_wb_exc    <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_is_load   <= w_is_load_nxt;
      r_funct3    <= w_funct3_nxt;
      r_off       <= w_off_nxt;
      r_waddr     <= w_waddr_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_be    <= w_mem_be_nxt;
      r_wb_valid  <= w_wb_valid_nxt;
      r_wb_wen    <= w_wb_wen_nxt;
      r_wb_waddr  <= w_wb_waddr_nxt;
      r_wb_wdata  <= w_wb_wdata_nxt;
      r_wb_exc    <= w_wb_exc_nxt;
    end
  end

  assign bus.ex_ready_o     = w_ready;
  assign bus.mem_req_o      = r_mem_req;
  assign bus.mem_we_o       = r_mem_we;
  assign bus.mem_addr_o     = r_mem_addr;
  assign bus.mem_wdata_o    = r_mem_wdata;
  assign bus.mem_be_o       = r_mem_be;
  assign bus.wb_valid_o     = r_wb_valid;
  assign bus.wb_reg_wen_o   = r_wb_wen;
  assign bus.wb_reg_waddr_o = r_wb_waddr;
  assign bus.wb_reg_wdata_o = r_wb_wdata;
  assign bus.wb_exc_o       = r_wb_exc;

endmodule

`default_nettype wire

// File: tb/tb_inst_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_mem_access
// Brief    : Directed bench for inst_mem_access with a behavioural reference
//            model of the writeback stream and bus request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_mem_access;

  localparam int TO = 4;
  localparam int K_PASS = 0, K_ILL = 1, K_MIS = 2, K_LD = 3, K_ST = 4;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  inst_mem_access_if #(.XLEN(32)) bus ();

  inst_mem_access #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  exc;
    bit          chk_data;
    int          at;
  } wb_t;

  wb_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;

  // expected bus request state
  logic        req_exp = 1'b0;
  logic        exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;

  // last observed DUT values, used for literal checks
  logic [3:0]  seen_be;
  logic [31:0] seen_addr, seen_wdata, seen_wb_wdata;
  logic        seen_we, seen_wb_wen;
  logic [1:0]  seen_wb_exc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic int model_kind(input logic [31:0] inst, input logic [31:0] addr);
    logic [2:0] f3;
    int bytes;
    f3    = inst[14:12];
    bytes = 1 << f3[1:0];
    if (inst[6:0] == 7'b0000011) begin
      if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return K_ILL;
      if ((int'(addr[1:0]) % bytes) != 0) return K_MIS;
      return K_LD;
    end
    if (inst[6:0] == 7'b0100011) begin
      if (!(f3 inside {3'd0, 3'd1, 3'd2})) return K_ILL;
      if ((int'(addr[1:0]) % bytes) != 0) return K_MIS;
      return K_ST;
    end
    return K_PASS;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int v;
    v = ((1 << (1 << f3[1:0])) - 1) << addr[1:0];
    return v[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sdata);
    if (f3[1:0] == 2'd0) return 32'(sdata[7:0]) * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return 32'(sdata[15:0]) * 32'h0001_0001;
    return sdata;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] v, mask;
    int nb;
    v  = rdata >> (8 * int'(addr[1:0]));
    nb = 8 * (1 << f3[1:0]);
    if (nb < 32) begin
      mask = (32'h1 << nb) - 32'h1;
      v    = v & mask;
      if (!f3[2] && v[nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    return {17'h15555, f3, 5'h0A, opc};
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    wb_t e;
    if (!rst_i) begin
      chk("mem_req", bus.mem_req_o, req_exp);
      if (req_exp && bus.mem_req_o) begin
        chk("mem_we", bus.mem_we_o, exp_we);
        chk("mem_addr", bus.mem_addr_o, exp_addr);
        chk("mem_be", bus.mem_be_o, exp_be);
        chk("mem_wdata", bus.mem_wdata_o, exp_wdata);
        seen_we = bus.mem_we_o;  seen_addr  = bus.mem_addr_o;
        seen_be = bus.mem_be_o;  seen_wdata = bus.mem_wdata_o;
      end
      if (bus.wb_valid_o) begin
        if (exp_q.size() == 0) begin
          fail("wb_unexpected");
        end else begin
          e = exp_q.pop_front();
          chk("wb_cycle", cyc, e.at);
          chk("wb_wen", bus.wb_reg_wen_o, e.wen);
          chk("wb_exc", bus.wb_exc_o, e.exc);
          if (e.chk_data) begin
            chk("wb_waddr", bus.wb_reg_waddr_o, e.waddr);
            chk("wb_wdata", bus.wb_reg_wdata_o, e.wdata);
          end
          seen_wb_wen = bus.wb_reg_wen_o;
          seen_wb_exc = bus.wb_exc_o;
          seen_wb_wdata = bus.wb_reg_wdata_o;
        end
      end else if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
        e = exp_q.pop_front();
        fail("wb_missing");
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                         output int acc);
    int n;
    n = 0;
    while (!bus.ex_ready_o && n < 20) begin
      step();
      n++;
    end
    if (!bus.ex_ready_o) fail("ready_wait");
    bus.ex_valid_i     = 1'b1;
    bus.ex_inst_i      = inst;
    bus.ex_addr_i      = addr;
    bus.ex_sdata_i     = sdata;
    bus.ex_reg_wen_i   = wen;
    bus.ex_reg_waddr_i = waddr;
    bus.ex_reg_wdata_i = wdata;
    step();
    bus.ex_valid_i = 1'b0;
    acc = cyc;
  endtask

  task automatic alu(input logic [4:0] waddr, input logic [31:0] wdata, input logic wen);
    int acc;
    wb_t e;
    present(32'h0000_0033, 32'h0, 32'h0, wen, waddr, wdata, acc);
    e.wen = wen && (waddr != 5'd0); e.waddr = waddr; e.wdata = wdata;
    e.exc = 2'b00; e.chk_data = 1'b1; e.at = acc;
    exp_q.push_back(e);
  endtask

  task automatic set_bus_exp(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] sdata);
    exp_we    = (model_kind(inst, addr) == K_ST);
    exp_addr  = {addr[31:2], 2'b00};
    exp_be    = model_be(inst[14:12], addr);
    exp_wdata = exp_we ? model_wdata(inst[14:12], sdata) : 32'h0;
  endtask

  // gnt_wait/rsp_wait < 0 means the event never arrives
  task automatic memop(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] waddr, input int gnt_wait, input int rsp_wait,
                       input logic [31:0] rdata);
    int kind, acc;
    wb_t e;
    kind = model_kind(inst, addr);
    e.wen = 1'b0; e.waddr = waddr; e.wdata = 32'h0; e.exc = 2'b00; e.chk_data = 1'b0; e.at = 0;
    if (kind == K_ILL || kind == K_MIS || kind == K_PASS) begin
      present(inst, addr, sdata, 1'b1, waddr, 32'hDEAD_BEEF, acc);
      e.exc = (kind == K_ILL) ? 2'b11 : 2'b01;
      e.at  = acc;
      exp_q.push_back(e);
      return;
    end
    set_bus_exp(inst, addr, sdata);
    present(inst, addr, sdata, 1'b0, waddr, 32'h0, acc);
    req_exp = 1'b1;
    chk("busy_ready", bus.ex_ready_o, 1'b0);
    if (gnt_wait < 0) begin
      repeat (TO - 1) step();
      e.exc = 2'b10; e.at = cyc + 1;
      exp_q.push_back(e);
      step();
      req_exp = 1'b0;
    end else begin
      repeat (gnt_wait) step();
      bus.mem_gnt_i = 1'b1;
      if (kind == K_ST) begin
        e.at = cyc + 1;
        exp_q.push_back(e);
      end
      step();
      bus.mem_gnt_i = 1'b0;
      req_exp = 1'b0;
      if (kind == K_LD) begin
        if (rsp_wait < 0) begin
          repeat (TO - 1) step();
          e.exc = 2'b10; e.at = cyc + 1;
          exp_q.push_back(e);
          step();
        end else begin
          repeat (rsp_wait) step();
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = rdata;
          e.wen = (waddr != 5'd0);
          e.wdata = model_load(inst[14:12], addr, rdata);
          e.chk_data = 1'b1;
          e.at = cyc + 1;
          exp_q.push_back(e);
          step();
          bus.mem_rvalid_i = 1'b0;
          bus.mem_rdata_i  = 32'h0;
        end
      end
    end
    chk("done_ready", bus.ex_ready_o, 1'b0);
    step();
    chk("idle_ready", bus.ex_ready_o, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acc;
    rst_i = 1'b1;
    bus.ex_valid_i = 1'b0; bus.ex_inst_i = 32'h0; bus.ex_addr_i = 32'h0; bus.ex_sdata_i = 32'h0;
    bus.ex_reg_wen_i = 1'b0; bus.ex_reg_waddr_i = 5'd0; bus.ex_reg_wdata_i = 32'h0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 32'h0;
    exp_we = 1'b0; exp_addr = 32'h0; exp_wdata = 32'h0; exp_be = 4'h0;
    step(); step();

    // reset state
    chk("rst_ready", bus.ex_ready_o, 1'b0);
    chk("rst_req", bus.mem_req_o, 1'b0);
    chk("rst_wb_valid", bus.wb_valid_o, 1'b0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
    chk("rst_wb_wdata", bus.wb_reg_wdata_o, 32'h0);
    rst_i = 1'b0;
    step();
    chk("post_rst_ready", bus.ex_ready_o, 1'b1);

    // pass-through burst, back to back
    for (int i = 1; i <= 4; i++) begin
      chk("burst_ready", bus.ex_ready_o, 1'b1);
      alu(5'(i), 32'(i) * 32'h11, 1'b1);
    end
    chk("burst_ready_end", bus.ex_ready_o, 1'b1);
    alu(5'd9, 32'h99, 1'b0);
    alu(5'd0, 32'h77, 1'b1);
    step(); step();

    // SB at 0x1003, grant after two wait cycles
    memop(mk(7'b0100011, 3'b000), 32'h1003, 32'h0000_00A5, 5'd3, 2, 0, 32'h0);
    chk("sb_be", seen_be, 4'b1000);
    chk("sb_addr", seen_addr, 32'h1000);
    chk("sb_wdata", seen_wdata, 32'hA5A5_A5A5);
    chk("sb_we", seen_we, 1'b1);
    chk("sb_wb_wen", seen_wb_wen, 1'b0);

    // SH upper half, SW with grant in the last allowed cycle
    memop(mk(7'b0100011, 3'b001), 32'h2006, 32'hFFFF_1234, 5'd4, 0, 0, 32'h0);
    chk("sh_be", seen_be, 4'b1100);
    chk("sh_wdata", seen_wdata, 32'h1234_1234);
    memop(mk(7'b0100011, 3'b010), 32'h2008, 32'hCAFE_BABE, 5'd4, TO - 1, 0, 32'h0);
    chk("sw_lastgnt_exc", seen_wb_exc, 2'b00);

    // loads with extension
    memop(mk(7'b0000011, 3'b000), 32'h2002, 32'h0, 5'd5, 0, 0, 32'h0080_0000);
    chk("lb_data", seen_wb_wdata, 32'hFFFF_FF80);
    chk("lb_be", seen_be, 4'b0100);
    chk("lb_mem_wdata", seen_wdata, 32'h0);
    memop(mk(7'b0000011, 3'b100), 32'h2002, 32'h0, 5'd6, 1, 1, 32'h0080_0000);
    chk("lbu_data", seen_wb_wdata, 32'h0000_0080);
    memop(mk(7'b0000011, 3'b101), 32'h2002, 32'h0, 5'd7, 0, 2, 32'hBEEF_0000);
    chk("lhu_data", seen_wb_wdata, 32'h0000_BEEF);
    memop(mk(7'b0000011, 3'b001), 32'h2000, 32'h0, 5'd8, 0, 0, 32'h1234_8001);
    chk("lh_data", seen_wb_wdata, 32'hFFFF_8001);
    memop(mk(7'b0000011, 3'b010), 32'h2004, 32'h0, 5'd9, 2, 0, 32'h89AB_CDEF);
    chk("lw_data", seen_wb_wdata, 32'h89AB_CDEF);

    // misaligned and illegal, back to back
    memop(mk(7'b0000011, 3'b010), 32'h3001, 32'h0, 5'd10, 0, 0, 32'h0);
    memop(mk(7'b0100011, 3'b001), 32'h3003, 32'h0, 5'd10, 0, 0, 32'h0);
    memop(mk(7'b0000011, 3'b011), 32'h3000, 32'h0, 5'd11, 0, 0, 32'h0);
    memop(mk(7'b0100011, 3'b100), 32'h3000, 32'h0, 5'd11, 0, 0, 32'h0);
    step();
    chk("ill_exc", seen_wb_exc, 2'b11);
    chk("ill_wen", seen_wb_wen, 1'b0);

    // timeouts: grant never, then response never
    memop(mk(7'b0000011, 3'b010), 32'h5000, 32'h0, 5'd12, -1, 0, 32'h0);
    chk("to_gnt_exc", seen_wb_exc, 2'b10);
    chk("to_gnt_wen", seen_wb_wen, 1'b0);
    memop(mk(7'b0000011, 3'b000), 32'h5001, 32'h0, 5'd13, 0, -1, 32'h0);
    chk("to_rsp_exc", seen_wb_exc, 2'b10);

    // reset during WAIT, late response must be ignored
    set_bus_exp(mk(7'b0000011, 3'b010), 32'h4000, 32'h0);
    present(mk(7'b0000011, 3'b010), 32'h4000, 32'h0, 1'b1, 5'd7, 32'h0, acc);
    req_exp = 1'b1;
    bus.mem_gnt_i = 1'b1;
    step();
    bus.mem_gnt_i = 1'b0;
    req_exp = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_ready", bus.ex_ready_o, 1'b0);
    step();
    chk("abort_req", bus.mem_req_o, 1'b0);
    chk("abort_we", bus.mem_we_o, 1'b0);
    chk("abort_addr", bus.mem_addr_o, 32'h0);
    chk("abort_wdata", bus.mem_wdata_o, 32'h0);
    chk("abort_be", bus.mem_be_o, 4'h0);
    chk("abort_wb_valid", bus.wb_valid_o, 1'b0);
    chk("abort_wb_wen", bus.wb_reg_wen_o, 1'b0);
    chk("abort_wb_waddr", bus.wb_reg_waddr_o, 32'h0);
    chk("abort_wb_exc", bus.wb_exc_o, 2'b00);
    rst_i = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h1234_5678;
    step();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'h0;
    chk("abort_no_wb", bus.wb_valid_o, 1'b0);
    chk("abort_idle_ready", bus.ex_ready_o, 1'b1);
    step();

    // LW to x0 never writes
    memop(mk(7'b0000011, 3'b010), 32'h4008, 32'h0, 5'd0, 0, 0, 32'hCAFE_F00D);
    chk("lw_x0_wen", seen_wb_wen, 1'b0);
    chk("lw_x0_data", seen_wb_wdata, 32'hCAFE_F00D);

    step(); step(); step();
    while (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      fail("wb_never_seen");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
